// File: rtl/pipelined_adder_tree.sv
// rtl/pipelined_adder_tree.sv - registered binary adder tree with valid/ready flow control
//
// Sums NUM_IN operands of DATA_W bits. Each tree level has one register stage.
// Operands are zero-extended (SIGNED=0) or sign-extended (SIGNED=1) by one bit at each level.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous pipeline clear; blocks input during the flush cycle
//   in_valid/in_ready     operand-set handshake
//   in_data               packed operands; operand j = in_data[j*DATA_W +: DATA_W]
//   out_valid/out_ready   result handshake
//   out_data              exact sum, DATA_W+LEVELS bits wide
module pipelined_adder_tree #(
    parameter  int DATA_W = 10,
    parameter  int NUM_IN = 4,
    parameter  int SIGNED = 0,
    localparam int LEVELS = $clog2(NUM_IN),
    localparam int OUT_W  = DATA_W + LEVELS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data
);

    localparam int NUM_PAD = 1 << LEVELS;

    logic [DATA_W-1:0] pad [NUM_PAD];
    logic [LEVELS:1]   v_q;
    logic [LEVELS:1]   v_prev;
    logic [LEVELS:1]   en;
    logic [LEVELS:1]   ld;
    logic              v0;

    // Level 0: input operands padded with zeros up to a power of two.
    always_comb begin
        for (int j = 0; j < NUM_PAD; j++) begin
            pad[j] = '0;
        end
        for (int j = 0; j < NUM_IN; j++) begin
            pad[j] = in_data[j*DATA_W +: DATA_W];
        end
    end

    // A stage may advance when it is empty or when every stage after it can
    // advance. The chain is flattened (OR of downstream empties and out_ready)
    // so no vector depends on its own bits.
    always_comb begin
        logic acc;
        for (int k = 1; k <= LEVELS; k++) begin
            acc = out_ready;
            for (int j = k; j <= LEVELS; j++) begin
                acc = acc | ~v_q[j];
            end
            en[k] = acc;
        end
    end

    assign in_ready = en[1] & ~flush;
    assign v0       = in_valid & in_ready;

    always_comb begin
        v_prev[1] = v0;
        for (int k = 2; k <= LEVELS; k++) begin
            v_prev[k] = v_q[k-1];
        end
        for (int k = 1; k <= LEVELS; k++) begin
            ld[k] = en[k] & v_prev[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else begin
            for (int k = 1; k <= LEVELS; k++) begin
                if (en[k]) begin
                    v_q[k] <= v_prev[k];
                end
            end
        end
    end

    // Level k nodes are DATA_W+k bits; each adds two extended level k-1 entries.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int W = DATA_W + k;
        for (genvar i = 0; i < (1 << (LEVELS - k)); i++) begin : g_node
            logic [W-2:0] a;
            logic [W-2:0] b;
            logic [W-1:0] s;
            logic [W-1:0] q;

            if (k == 1) begin : g_leaf
                assign a = pad[2*i];
                assign b = pad[2*i+1];
            end else begin : g_inner
                assign a = g_lvl[k-1].g_node[2*i].q;
                assign b = g_lvl[k-1].g_node[2*i+1].q;
            end

            if (SIGNED != 0) begin : g_sext
                assign s = {a[W-2], a} + {b[W-2], b};
            end else begin : g_zext
                assign s = {1'b0, a} + {1'b0, b};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (ld[k]) begin
                    q <= s;
                end
            end
        end
    end

    assign out_valid = v_q[LEVELS];
    assign out_data  = g_lvl[LEVELS].g_node[0].q;

endmodule

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
- Parametrised successor to the fixed 3-operand, 2-cycle pipelined adder.
- Sums NUM_IN operands of DATA_W bits through a registered binary adder tree, with one register stage per tree level.
- Adds valid/ready flow control with per-stage bubble collapsing, a synchronous flush, and a signed or unsigned mode.
- Sits between operand producers (datapath registers, FIFO outputs) and a downstream consumer that may stall.

Parameters:
- DATA_W, 10, operand width in bits (>=2).
- NUM_IN, 4, operand count (2..16; non-power-of-2 allowed).
- SIGNED, 0, 0 = operands unsigned and zero-extended; 1 = two's complement and sign-extended.
- LEVELS, derived = ceil(log2(NUM_IN)), pipeline depth. Local; not overridable.
- OUT_W, derived = DATA_W + LEVELS, result width. Local; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline clear, active-high.
- in_valid  in  1  in_data holds a valid operand set.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  NUM_IN*DATA_W  packed operands; operand j = in_data[j*DATA_W +: DATA_W].
- out_valid  out  1  out_data holds a valid sum.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  OUT_W  sum of one operand set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits = 0; all stage data registers = 0.
  - out_valid = 0, out_data = 0, in_ready = 1 once flush is low.
- Tree structure:
  - Level 0 = the input operands, padded to 2^LEVELS entries with zeros.
  - Level k (1..LEVELS) holds 2^(LEVELS-k) registered sums, each DATA_W+k bits wide.
  - Each sum adds two level k-1 entries, each extended by 1 bit (sign-extended if SIGNED=1, zero-extended otherwise).
  - Level LEVELS has a single entry, which drives out_data.
- Result:
  - out_data equals the exact sum of the NUM_IN operands.
  - OUT_W bits are always sufficient, so overflow is impossible by construction.
- Latency and throughput:
  - An operand set accepted at edge t appears with out_valid=1 after edge t+LEVELS-1, i.e. LEVELS edges after acceptance, provided there is no stall.
  - Sustained throughput is 1 set/cycle while out_ready=1.
- Stage control (v[k] = valid of level k):
  - en[LEVELS] = ~v[LEVELS] | out_ready.
  - en[k] = ~v[k] | en[k+1] for k < LEVELS.
  - in_ready = en[1] & ~flush.
  - On a rising edge with en[k]=1: v[k] <= v[k-1], where v[0] = in_valid & in_ready.
  - Level k data loads only when en[k] & v[k-1]; otherwise it holds.
- Stall and ordering:
  - A stalled stage holds data and valid unchanged.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
  - No data is duplicated, dropped or reordered.
- Handshake rules:
  - out_data is stable while out_valid=1 and out_ready=0.
  - in_valid may assert regardless of in_ready. Transfer occurs only when both are high.
- Flush:
  - On a rising edge with flush=1, all v[k] <= 0. Data registers are don't-care.
  - Input presented in the flush cycle is not accepted (in_ready=0).
  - Flush overrides any simultaneous load or drain.
  - out_valid is 0 in the cycle after the flush edge.
- Reset mid-operation: all in-flight sets are discarded immediately; no partial result is ever presented.
- Combinational paths:
  - out_ready to in_ready is a combinational path through the en chain.
  - There is no combinational path from in_data to out_data.

Test Plan:
- Defaults (DATA_W=10, NUM_IN=4, SIGNED=0), out_ready=1:
  - Drive one set {1023,1023,1023,1023} with in_valid for one cycle.
  - Require out_valid=1 for exactly one cycle, 2 cycles after acceptance, with out_data=12'hFFC (4092).
- Streaming, defaults:
  - Drive sets {k,2k,3k,4k} for k=1..20 on consecutive cycles with out_ready=1.
  - Require in_ready held at 1 and results 10k emitted back-to-back, in order.
- SIGNED=1, DATA_W=8, NUM_IN=3 (LEVELS=2, OUT_W=10):
  - Set {-128,-128,-128} -> out_data=10'h280 (-384).
  - Set {127,-1,5} -> out_data=131.
- Backpressure:
  - Stream 6 sets with out_ready=0 from the 2nd output onward.
  - Require in_ready to drop after the pipeline fills (LEVELS+... entries held, no loss) and out_data stable while stalled.
  - Release out_ready; require all 6 sums in order.
- Flush:
  - With 2 sets in flight, pulse flush for one cycle while in_valid=1.
  - Require in_ready=0 in the flush cycle and out_valid=0 the next cycle.
  - Require neither in-flight sum nor the flush-cycle set to appear afterwards.
  - Require a new set to produce a correct sum with normal latency.
- Reset mid-stream:
  - Assert rst_n=0 asynchronously between edges with the pipeline full and out_ready=0.
  - Require out_valid=0 and out_data=0 immediately, before the next edge.
  - After release, require in_ready=1 and correct operation with no stale outputs.
